// File: rtl/memctl_refill_sender_pkg.sv
// Shared types and constants for the memory-controller refill sender.
// Holds the cache geometry config (mpc_cfg_t), memory beat sizing and the refill FSM states.
// Ports: none (package).
package memctl_refill_sender_pkg;

  typedef struct packed {
    int unsigned nlineWidth;    // total line-id width {way, set}
    int unsigned setWidth;      // set index width (low bits of the line id)
    int unsigned wayIndexWidth; // way index width (high bits of the line id)
  } mpc_cfg_t;

  localparam int MemBeatW    = 32;
  localparam int RefillBeats = 4;
  localparam int LineW       = MemBeatW * RefillBeats;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RECV,
    SEND
  } refill_state_t;

endpackage

// File: rtl/memctl_miss_fifo.sv
// In-order miss queue: Depth entries of dat_t, no bypass, no duplicate filtering.
// Latency: a pushed entry is visible at head_o the cycle after the push.
// Backpressure: full_o/empty_o are decoded from the occupancy register; push when full and pop when empty are dropped.
// Ports: clk, rst (sync, active-high), push_i/push_dat_i, pop_i, full_o, empty_o, head_o.
module memctl_miss_fifo #(
  parameter int  Depth = 4,
  parameter type dat_t = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  dat_t push_dat_i,
  input  logic pop_i,
  output logic full_o,
  output logic empty_o,
  output dat_t head_o
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW+1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW+1)'(Depth);

  dat_t            mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   cnt_q;
  logic            push_ok, pop_ok;

  assign full_o  = (cnt_q == CntFull);
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrOne;
      if (push_ok && !pop_ok)      cnt_q <= cnt_q + CntOne;
      else if (!push_ok && pop_ok) cnt_q <= cnt_q - CntOne;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/memctl_refill_sender.sv
// Refill sender: queues missed line ids, reads each line as 4x32b beats from memory, emits one 128b refill.
// Latency: miss accepted in T -> mem_req_valid in T+2; last beat in R -> memctl_refill_valid in R+1.
// Backpressure: miss_ready drops when the queue is full; valid outputs hold until their ready, one line in flight.
// Ports: miss_* (in), mem_req_* (out), mem_rsp_* (in, no backpressure), memctl_refill_* (out), busy.
module memctl_refill_sender
  import memctl_refill_sender_pkg::*;
#(
  parameter mpc_cfg_t Cfg          = '0,
  parameter type      nlineWidth_t = logic,
  parameter int       MissqDepth   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_valid,
  output logic                miss_ready,
  input  nlineWidth_t         miss_id,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output nlineWidth_t         mem_req_id,
  input  logic                mem_rsp_valid,
  input  logic [MemBeatW-1:0] mem_rsp_data,
  output logic                memctl_refill_valid,
  input  logic                memctl_refill_ready,
  output nlineWidth_t         memctl_refill_id,
  output logic [LineW-1:0]    memctl_refill_data,
  output logic                busy
);

  refill_state_t    state_q;
  nlineWidth_t      cur_id_q;
  logic [1:0]       beat_cnt_q;
  logic [LineW-1:0] line_q;
  logic             req_vld_q, refill_vld_q;

  logic        fifo_full, fifo_empty, fifo_pop;
  nlineWidth_t fifo_head;

  // Pop only from IDLE; a concurrent push still lands because the FIFO handles both.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  memctl_miss_fifo #(
    .Depth (MissqDepth),
    .dat_t (nlineWidth_t)
  ) u_missq (
    .clk        (clk),
    .rst        (rst),
    .push_i     (miss_valid),
    .push_dat_i (miss_id),
    .pop_i      (fifo_pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cur_id_q     <= '0;
      beat_cnt_q   <= '0;
      line_q       <= '0;
      req_vld_q    <= 1'b0;
      refill_vld_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_id_q  <= fifo_head;
            req_vld_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            req_vld_q  <= 1'b0;
            beat_cnt_q <= '0;
            state_q    <= RECV;
          end
        end
        RECV: begin
          // Beats may arrive with gaps; only cycles with mem_rsp_valid advance the count.
          if (mem_rsp_valid) begin
            line_q[int'(beat_cnt_q)*MemBeatW +: MemBeatW] <= mem_rsp_data;
            beat_cnt_q <= beat_cnt_q + 2'd1;
            if (beat_cnt_q == 2'd3) begin
              refill_vld_q <= 1'b1;
              state_q      <= SEND;
            end
          end
        end
        SEND: begin
          if (memctl_refill_ready) begin
            refill_vld_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Valids and readies come straight from registers: no ready-to-valid combinational path.
  assign miss_ready          = !fifo_full;
  assign mem_req_valid       = req_vld_q;
  assign mem_req_id          = cur_id_q;
  assign memctl_refill_valid = refill_vld_q;
  assign memctl_refill_id    = cur_id_q;
  assign memctl_refill_data  = line_q;
  assign busy                = (state_q != IDLE) || !fifo_empty;

  // A response beat outside RECV has nowhere to go; it is dropped but reported.
  stray_rsp_a: assert property (@(posedge clk) disable iff (rst)
    !(mem_rsp_valid && (state_q != RECV)))
    else $warning("memctl_refill_sender: stray mem_rsp_valid outside RECV dropped");

  // When a geometry is supplied, the line-id type must match its width.
  cfg_width_a: assert property (@(posedge clk)
    (Cfg.nlineWidth == 0) || ($bits(nlineWidth_t) == int'(Cfg.nlineWidth)));

endmodule

// File: tb/tb_memctl_refill_sender.sv
module tb_memctl_refill_sender;
  import memctl_refill_sender_pkg::*;

  typedef logic [7:0] id_t;
  localparam mpc_cfg_t TbCfg = '{nlineWidth: 8, setWidth: 6, wayIndexWidth: 2};

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid, miss_ready;
  id_t          miss_id;
  logic         mem_req_valid, mem_req_ready;
  id_t          mem_req_id;
  logic         mem_rsp_valid;
  logic [31:0]  mem_rsp_data;
  logic         memctl_refill_valid, memctl_refill_ready;
  id_t          memctl_refill_id;
  logic [127:0] memctl_refill_data;
  logic         busy;

  memctl_refill_sender #(
    .Cfg          (TbCfg),
    .nlineWidth_t (id_t),
    .MissqDepth   (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .miss_valid          (miss_valid),
    .miss_ready          (miss_ready),
    .miss_id             (miss_id),
    .mem_req_valid       (mem_req_valid),
    .mem_req_ready       (mem_req_ready),
    .mem_req_id          (mem_req_id),
    .mem_rsp_valid       (mem_rsp_valid),
    .mem_rsp_data        (mem_rsp_data),
    .memctl_refill_valid (memctl_refill_valid),
    .memctl_refill_ready (memctl_refill_ready),
    .memctl_refill_id    (memctl_refill_id),
    .memctl_refill_data  (memctl_refill_data),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    id_t             id;
    logic [3:0][31:0] beats;    // beats[0] arrives first
    int              gap;       // idle cycles before each beat
    int              stall;     // cycles refill_ready is held low
    bit              stray;     // extra rsp beat during SEND
    logic [127:0]    exp_data;
  } vec_t;

  vec_t vecs [5];
  id_t  qids [6];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   got, nb;
  bit   hs_req, hs_ref, acc, in_recv;
  id_t  cur;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete miss -> refill transaction starting from an idle, empty DUT.
  task automatic run_one(input int idx, input vec_t v);
    miss_valid = 1'b1;
    miss_id    = v.id;
    step();
    miss_valid = 1'b0;
    chk($sformatf("v%0d_req_not_early", idx), mem_req_valid, 0);
    step();
    chk($sformatf("v%0d_req_vld", idx), mem_req_valid, 1);
    chk($sformatf("v%0d_req_id", idx), mem_req_id, v.id);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      repeat (v.gap) step();
      if (b == 3) chk($sformatf("v%0d_refill_not_early", idx), memctl_refill_valid, 0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = v.beats[b];
      step();
      mem_rsp_valid = 1'b0;
    end
    for (int s = 0; s <= v.stall; s++) begin
      chk($sformatf("v%0d_s%0d_refill_vld", idx, s), memctl_refill_valid, 1);
      chk($sformatf("v%0d_s%0d_refill_id", idx, s), memctl_refill_id, v.id);
      chk($sformatf("v%0d_s%0d_refill_data", idx, s), memctl_refill_data, v.exp_data);
      if (s == v.stall) memctl_refill_ready = 1'b1;
      if (s == 0 && v.stray) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0BAD0;
      end
      step();
      mem_rsp_valid       = 1'b0;
      memctl_refill_ready = 1'b0;
    end
    chk($sformatf("v%0d_refill_done", idx), memctl_refill_valid, 0);
    chk($sformatf("v%0d_idle", idx), busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{id: 8'h2A, beats: {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
                gap: 0, stall: 0, stray: 1'b0,
                exp_data: 128'h44444444_33333333_22222222_11111111};
    vecs[1] = '{id: 8'hC3, beats: {32'hF0F0F0F0, 32'h0F0F0F0F, 32'h5A5A5A5A, 32'hA5A5A5A5},
                gap: 0, stall: 5, stray: 1'b0,
                exp_data: 128'hF0F0F0F0_0F0F0F0F_5A5A5A5A_A5A5A5A5};
    vecs[2] = '{id: 8'hFF, beats: {32'h12345678, 32'hFFFFFFFF, 32'h00000000, 32'hDEADBEEF},
                gap: 2, stall: 2, stray: 1'b1,
                exp_data: 128'h12345678_FFFFFFFF_00000000_DEADBEEF};
    vecs[3] = '{id: 8'h00, beats: {32'h00000004, 32'h00000003, 32'h00000002, 32'h00000001},
                gap: 1, stall: 0, stray: 1'b0,
                exp_data: 128'h00000004_00000003_00000002_00000001};
    vecs[4] = '{id: 8'h05, beats: {32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304},
                gap: 0, stall: 1, stray: 1'b0,
                exp_data: 128'h0D0E0F10_090A0B0C_05060708_01020304};
    qids = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

    rst = 1'b1;
    miss_valid = 1'b0; miss_id = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    memctl_refill_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_miss_ready", miss_ready, 1);
    chk("rst_req_vld", mem_req_valid, 0);
    chk("rst_refill_vld", memctl_refill_valid, 0);
    chk("rst_refill_id", memctl_refill_id, 0);
    chk("rst_refill_data", memctl_refill_data, 0);
    chk("rst_busy", busy, 0);

    for (int i = 0; i < 4; i++) run_one(i, vecs[i]);

    // Queue fill while memory stalls the first request.
    mem_req_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      miss_valid = 1'b1;
      miss_id    = qids[k];
      chk($sformatf("fill%0d_miss_ready", k), miss_ready, 1);
      step();
    end
    miss_id = qids[5];
    chk("full_miss_ready", miss_ready, 0);
    chk("full_busy", busy, 1);
    chk("full_req_vld", mem_req_valid, 1);
    chk("full_req_id", mem_req_id, qids[0]);
    step();
    chk("full_hold_miss_ready", miss_ready, 0);

    // Drain: answer every request, the 6th miss enters once space frees up.
    mem_req_ready = 1'b1;
    memctl_refill_ready = 1'b1;
    got = 0; nb = 0; in_recv = 1'b0; cur = '0;
    for (int cyc = 0; cyc < 400 && got < 6; cyc++) begin
      hs_req = mem_req_valid;
      hs_ref = memctl_refill_valid;
      acc    = miss_valid && miss_ready;
      mem_rsp_valid = in_recv;
      mem_rsp_data  = {cur, 24'(nb)};
      if (hs_req) cur = mem_req_id;
      if (hs_ref) begin
        chk($sformatf("drain%0d_id", got), memctl_refill_id, qids[got]);
        chk($sformatf("drain%0d_data", got), memctl_refill_data,
            {qids[got], 24'd3, qids[got], 24'd2, qids[got], 24'd1, qids[got], 24'd0});
        got++;
      end
      step();
      if (in_recv) begin
        nb++;
        if (nb == 4) in_recv = 1'b0;
      end
      if (hs_req) begin
        in_recv = 1'b1;
        nb = 0;
      end
      if (acc) miss_valid = 1'b0;
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    memctl_refill_ready = 1'b0;
    miss_valid = 1'b0;
    chk("drain_count", got, 6);
    chk("drain_idle", busy, 0);

    // Reset in the middle of a line fill.
    miss_valid = 1'b1; miss_id = 8'h33;
    step();
    miss_valid = 1'b0;
    step();
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hAAAA0001;
    step();
    mem_rsp_data = 32'hAAAA0002;
    step();
    mem_rsp_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst = 1'b1;
    step();
    chk("mrst_miss_ready", miss_ready, 1);
    chk("mrst_req_vld", mem_req_valid, 0);
    chk("mrst_refill_vld", memctl_refill_valid, 0);
    chk("mrst_refill_id", memctl_refill_id, 0);
    chk("mrst_refill_data", memctl_refill_data, 0);
    chk("mrst_busy", busy, 0);
    rst = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBADBAD00;
    step();
    mem_rsp_valid = 1'b0;
    chk("stray_busy", busy, 0);
    chk("stray_refill_vld", memctl_refill_valid, 0);
    chk("stray_refill_data", memctl_refill_data, 0);
    chk("stray_req_vld", mem_req_valid, 0);
    run_one(4, vecs[4]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
